// File: rtl/pinwheel_hart_sched.sv
// Round-robin hart scheduler for the pinwheel barrel core: per-hart PC/enable/in-flight table.
// Define PINWHEEL_SCHED_STATS_EN to build the per-hart retire counters behind stat_count.
module pinwheel_hart_sched #(
  parameter int unsigned          HART_BITS = 3,
  parameter int unsigned          PC_WIDTH  = 24,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = 24'h400000
) (
  input  logic                         clock,
  input  logic                         tock_reset_in,
  input  logic                         issue_ready,
  output logic                         issue_valid,
  output logic [31:0]                  issue_hpc,
  input  logic                         retire_valid,
  input  logic [HART_BITS-1:0]         retire_hart,
  input  logic [31:0]                  retire_next_hpc,
  input  logic                         retire_halt,
  input  logic                         ctl_valid,
  input  logic                         ctl_start,
  input  logic [HART_BITS-1:0]         ctl_hart,
  input  logic [PC_WIDTH-1:0]          ctl_pc,
  output logic [(1<<HART_BITS)-1:0]    hart_enabled,
  output logic [(1<<HART_BITS)-1:0]    hart_inflight,
  output logic                         err_retire,
  output logic                         err_migrate,
  input  logic [HART_BITS-1:0]         stat_hart,
  output logic [31:0]                  stat_count
);

  localparam int unsigned HART_COUNT = 1 << HART_BITS;

  logic [PC_WIDTH-1:0]   pc_q [HART_COUNT];
  logic [PC_WIDTH-1:0]   pc_d [HART_COUNT];
  logic [HART_COUNT-1:0] en_q, en_d;
  logic [HART_COUNT-1:0] busy_q, busy_d;
  logic [HART_BITS-1:0]  last_q, last_d;
  logic                  err_retire_q, err_retire_d;
  logic                  err_migrate_q, err_migrate_d;

  logic [HART_COUNT-1:0] runnable;
  logic                  sel_found;
  logic [HART_BITS-1:0]  sel_hart;
  logic [HART_BITS-1:0]  cand;
  logic [HART_BITS-1:0]  ret_t;
  logic [PC_WIDTH-1:0]   ret_p;
  logic                  retire_ok;
  logic                  start_take;

  assign runnable = en_q & ~busy_q;
  assign ret_t    = retire_next_hpc[PC_WIDTH +: HART_BITS];
  assign ret_p    = retire_next_hpc[PC_WIDTH-1:0];

  // Search order last+1, last+2, ... wraps naturally through HART_BITS truncation.
  always_comb begin
    sel_found = 1'b0;
    sel_hart  = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= HART_COUNT; i++) begin
      cand = HART_BITS'(32'(last_q) + i);
      if (!sel_found && runnable[cand]) begin
        sel_found = 1'b1;
        sel_hart  = cand;
      end
    end
  end

  always_comb begin
    issue_valid                          = sel_found;
    issue_hpc                            = '0;
    issue_hpc[PC_WIDTH-1:0]              = pc_q[sel_hart];
    issue_hpc[PC_WIDTH +: HART_BITS]     = sel_hart;
  end

  assign retire_ok  = retire_valid & busy_q[retire_hart];
  assign start_take = ctl_valid & ctl_start & ~en_q[ctl_hart] & ~busy_q[ctl_hart];

  always_comb begin
    pc_d          = pc_q;
    en_d          = en_q;
    busy_d        = busy_q;
    last_d        = last_q;
    err_retire_d  = err_retire_q;
    err_migrate_d = err_migrate_q;

    if (sel_found && issue_ready) begin
      busy_d[sel_hart] = 1'b1;
      last_d           = sel_hart;
    end

    if (retire_valid && !busy_q[retire_hart]) begin
      err_retire_d = 1'b1;
    end else if (retire_ok) begin
      busy_d[retire_hart] = 1'b0;
      if (ret_t == retire_hart) begin
        pc_d[retire_hart] = ret_p;
        if (retire_halt) en_d[retire_hart] = 1'b0;
      end else begin
        en_d[retire_hart] = 1'b0;
        // A START landing on the same target this cycle counts as an occupant.
        if (en_q[ret_t] || busy_q[ret_t] || (start_take && ctl_hart == ret_t)) begin
          err_migrate_d = 1'b1;
        end else begin
          pc_d[ret_t] = ret_p;
          en_d[ret_t] = 1'b1;
        end
      end
    end

    // Control is applied last so STOP overrides any enable written by a retire.
    if (ctl_valid) begin
      if (!ctl_start) begin
        en_d[ctl_hart] = 1'b0;
      end else if (start_take) begin
        pc_d[ctl_hart] = ctl_pc;
        en_d[ctl_hart] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tock_reset_in) begin
      for (int unsigned i = 0; i < HART_COUNT; i++) begin
        pc_q[i] <= '0;
      end
      pc_q[0]       <= RESET_PC;
      en_q          <= HART_COUNT'(1);
      busy_q        <= '0;
      last_q        <= '1;
      err_retire_q  <= 1'b0;
      err_migrate_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      last_q        <= last_d;
      err_retire_q  <= err_retire_d;
      err_migrate_q <= err_migrate_d;
    end
  end

  assign hart_enabled  = en_q;
  assign hart_inflight = busy_q;
  assign err_retire    = err_retire_q;
  assign err_migrate   = err_migrate_q;

`ifdef PINWHEEL_SCHED_STATS_EN
  logic [31:0] cnt_q [HART_COUNT];
  logic [31:0] cnt_d [HART_COUNT];

  always_comb begin
    cnt_d = cnt_q;
    if (retire_ok) begin
      cnt_d[retire_hart] = cnt_q[retire_hart] + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (tock_reset_in) begin
      for (int unsigned i = 0; i < HART_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_count = cnt_q[stat_hart];
`else
  logic unused_stat_hart;
  assign unused_stat_hart = ^stat_hart;
  assign stat_count       = '0;
`endif

  generate
    if (PC_WIDTH + HART_BITS < 32) begin : g_hpc_hi
      logic unused_hpc_hi;
      assign unused_hpc_hi = ^retire_next_hpc[31:PC_WIDTH+HART_BITS];
    end
  endgenerate

endmodule

// File: tb/tb_pinwheel_hart_sched.sv
// Directed bench for pinwheel_hart_sched: issue rotation, migration, STOP/START, errors, stats.
module tb_pinwheel_hart_sched;

  logic        clock;
  logic        tock_reset_in;
  logic        issue_ready;
  logic        issue_valid;
  logic [31:0] issue_hpc;
  logic        retire_valid;
  logic [2:0]  retire_hart;
  logic [31:0] retire_next_hpc;
  logic        retire_halt;
  logic        ctl_valid;
  logic        ctl_start;
  logic [2:0]  ctl_hart;
  logic [23:0] ctl_pc;
  logic [7:0]  hart_enabled;
  logic [7:0]  hart_inflight;
  logic        err_retire;
  logic        err_migrate;
  logic [2:0]  stat_hart;
  logic [31:0] stat_count;

  int checks = 0;
  int errors = 0;

`ifdef PINWHEEL_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pinwheel_hart_sched #(
    .HART_BITS (3),
    .PC_WIDTH  (24),
    .RESET_PC  (24'h400000)
  ) dut (
    .clock           (clock),
    .tock_reset_in   (tock_reset_in),
    .issue_ready     (issue_ready),
    .issue_valid     (issue_valid),
    .issue_hpc       (issue_hpc),
    .retire_valid    (retire_valid),
    .retire_hart     (retire_hart),
    .retire_next_hpc (retire_next_hpc),
    .retire_halt     (retire_halt),
    .ctl_valid       (ctl_valid),
    .ctl_start       (ctl_start),
    .ctl_hart        (ctl_hart),
    .ctl_pc          (ctl_pc),
    .hart_enabled    (hart_enabled),
    .hart_inflight   (hart_inflight),
    .err_retire      (err_retire),
    .err_migrate     (err_migrate),
    .stat_hart       (stat_hart),
    .stat_count      (stat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    issue_ready     = 1'b0;
    retire_valid    = 1'b0;
    retire_hart     = '0;
    retire_next_hpc = '0;
    retire_halt     = 1'b0;
    ctl_valid       = 1'b0;
    ctl_start       = 1'b0;
    ctl_hart        = '0;
    ctl_pc          = '0;
  endtask

  task automatic do_issue();
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic do_retire(input logic [2:0] h, input logic [31:0] hpc, input logic halt);
    retire_valid    = 1'b1;
    retire_hart     = h;
    retire_next_hpc = hpc;
    retire_halt     = halt;
    tick();
    retire_valid    = 1'b0;
    retire_halt     = 1'b0;
  endtask

  task automatic do_ctl(input logic start, input logic [2:0] h, input logic [23:0] pc);
    ctl_valid = 1'b1;
    ctl_start = start;
    ctl_hart  = h;
    ctl_pc    = pc;
    tick();
    ctl_valid = 1'b0;
  endtask

  task automatic do_reset();
    tock_reset_in = 1'b1;
    tick();
    tock_reset_in = 1'b0;
  endtask

  logic [2:0]  hist_hart [16];
  logic [23:0] hist_pc   [16];

  initial begin
    logic [2:0]  h;
    logic [23:0] p;

    clear_inputs();
    stat_hart     = '0;
    tock_reset_in = 1'b1;
    tick();
    tick();
    tock_reset_in = 1'b0;

    // Reset state
    check_eq("rst_valid",   32'(issue_valid),   32'd1);
    check_eq("rst_hpc",     issue_hpc,          32'h0040_0000);
    check_eq("rst_en",      32'(hart_enabled),  32'h01);
    check_eq("rst_busy",    32'(hart_inflight), 32'h00);
    check_eq("rst_err_r",   32'(err_retire),    32'd0);
    check_eq("rst_err_m",   32'(err_migrate),   32'd0);
    check_eq("rst_stat",    stat_count,         32'd0);

    // Single hart: issue, gap, retire with pc+4
    for (int k = 0; k < 4; k++) begin
      check_eq("solo_hpc", issue_hpc, 32'h0040_0000 + 32'(4 * k));
      do_issue();
      check_eq("solo_busy",  32'(hart_inflight), 32'h01);
      check_eq("solo_gap",   32'(issue_valid),   32'd0);
      do_retire(3'd0, 32'h0040_0004 + 32'(4 * k), 1'b0);
      check_eq("solo_idle",  32'(hart_inflight), 32'h00);
    end

    // All eight harts, 3-cycle retire latency, one issue per cycle
    for (int i = 1; i < 8; i++) do_ctl(1'b1, 3'(i), 24'(32'h1000 * i));
    check_eq("all_en", 32'(hart_enabled), 32'hFF);
    for (int k = 0; k < 19; k++) begin
      issue_ready = (k < 16);
      if (k < 16) begin
        h = 3'((k + 1) % 8);
        p = (h == 3'd0) ? 24'h400010 : 24'(32'h1000 * int'(h));
        if (k >= 8) p = p + 24'd4;
        hist_hart[k] = h;
        hist_pc[k]   = p;
        check_eq("rr_valid", 32'(issue_valid), 32'd1);
        check_eq("rr_hpc",   issue_hpc,        32'({h, p}));
      end
      if (k >= 3) begin
        retire_valid    = 1'b1;
        retire_hart     = hist_hart[k-3];
        retire_next_hpc = 32'({hist_hart[k-3], hist_pc[k-3] + 24'd4});
      end else begin
        retire_valid = 1'b0;
      end
      tick();
    end
    clear_inputs();
    check_eq("rr_drain", 32'(hart_inflight), 32'h00);

    // Migration hart 2 -> idle hart 5, then a colliding migration
    for (int i = 0; i < 8; i++) if (i != 2) do_ctl(1'b0, 3'(i), 24'h0);
    check_eq("mig_en0",  32'(hart_enabled), 32'h04);
    check_eq("mig_hpc0", issue_hpc,         32'h0200_2008);
    do_issue();
    check_eq("mig_busy", 32'(hart_inflight), 32'h04);
    do_retire(3'd2, 32'h0500_2000, 1'b0);
    check_eq("mig_en1",  32'(hart_enabled), 32'h20);
    check_eq("mig_err0", 32'(err_migrate),  32'd0);
    check_eq("mig_hpc1", issue_hpc,         32'h0500_2000);
    do_ctl(1'b1, 3'd2, 24'h002100);
    check_eq("mig_hpc2", issue_hpc, 32'h0500_2000);
    do_issue();
    check_eq("mig_hpc3", issue_hpc, 32'h0200_2100);
    do_retire(3'd5, 32'h0500_2040, 1'b0);
    do_issue();
    check_eq("mig_hpc4", issue_hpc, 32'h0500_2040);
    do_retire(3'd2, 32'h0500_2000, 1'b0);
    check_eq("mig_err1", 32'(err_migrate),   32'd1);
    check_eq("mig_en2",  32'(hart_enabled),  32'h20);
    check_eq("mig_idle", 32'(hart_inflight), 32'h00);
    check_eq("mig_keep", issue_hpc,          32'h0500_2040);

    // STOP hart 3 in the cycle it issues
    do_ctl(1'b1, 3'd3, 24'h003000);
    check_eq("stop_hpc0", issue_hpc, 32'h0300_3000);
    issue_ready = 1'b1;
    do_ctl(1'b0, 3'd3, 24'h0);
    issue_ready = 1'b0;
    check_eq("stop_en",   32'(hart_enabled),  32'h20);
    check_eq("stop_busy", 32'(hart_inflight), 32'h08);
    check_eq("stop_hpc1", issue_hpc,          32'h0500_2040);
    do_retire(3'd3, 32'h0300_3004, 1'b0);
    check_eq("stop_en2",  32'(hart_enabled),  32'h20);
    check_eq("stop_idle", 32'(hart_inflight), 32'h00);
    do_issue();
    check_eq("stop_noiss", 32'(issue_valid), 32'd0);
    do_retire(3'd5, 32'h0500_2044, 1'b0);
    check_eq("stop_hpc2", issue_hpc, 32'h0500_2044);
    do_ctl(1'b1, 3'd3, 24'h005000);
    check_eq("start_hpc", issue_hpc, 32'h0300_5000);

    // Retire of a hart that is not in flight
    do_retire(3'd4, 32'h0400_4444, 1'b0);
    check_eq("eret_flag", 32'(err_retire),    32'd1);
    check_eq("eret_en",   32'(hart_enabled),  32'h28);
    check_eq("eret_busy", 32'(hart_inflight), 32'h00);
    check_eq("eret_hpc",  issue_hpc,          32'h0300_5000);
    tick();
    check_eq("eret_stky", 32'(err_retire),  32'd1);
    check_eq("emig_stky", 32'(err_migrate), 32'd1);
    do_reset();
    check_eq("rst2_err_r", 32'(err_retire),   32'd0);
    check_eq("rst2_err_m", 32'(err_migrate),  32'd0);
    check_eq("rst2_en",    32'(hart_enabled), 32'h01);
    check_eq("rst2_hpc",   issue_hpc,         32'h0040_0000);
    do_retire(3'd0, 32'h0040_0004, 1'b0);
    check_eq("post_rst_err", 32'(err_retire), 32'd1);
    check_eq("post_rst_hpc", issue_hpc,       32'h0040_0000);
    do_reset();

    // Statistics: ten retires of hart 1, then a halting retire
    do_ctl(1'b0, 3'd0, 24'h0);
    do_ctl(1'b1, 3'd1, 24'h000100);
    check_eq("st_hpc0", issue_hpc, 32'h0100_0100);
    for (int i = 0; i < 10; i++) begin
      do_issue();
      do_retire(3'd1, 32'h0100_0100 + 32'(4 * (i + 1)), 1'b0);
    end
    check_eq("st_hpc1", issue_hpc,         32'h0100_0128);
    check_eq("st_err",  32'(err_retire),   32'd0);
    stat_hart = 3'd1;
    #1;
    check_eq("st_cnt1", stat_count, STATS ? 32'd10 : 32'd0);
    stat_hart = 3'd0;
    #1;
    check_eq("st_cnt0", stat_count, 32'd0);
    do_issue();
    do_retire(3'd1, 32'h0100_012C, 1'b1);
    check_eq("halt_en",    32'(hart_enabled), 32'h00);
    check_eq("halt_valid", 32'(issue_valid),  32'd0);
    stat_hart = 3'd1;
    #1;
    check_eq("st_cnt2", stat_count, STATS ? 32'd11 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
